// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory request/response, decoder handoff and branch redirect.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [15:0]       imem_rdata;
  logic              instr_valid;
  logic [15:0]       instruction;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instr_valid, instruction, instr_pc,
    input  imem_ready, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );

  // Memory / decoder / branch side
  modport slave (
    input  imem_req, imem_addr, instr_valid, instruction, instr_pc,
    output imem_ready, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps one halfword request in flight,
// buffers returned instructions with their PC and hands them to the decoder.
module fetch_unit #(
  parameter int unsigned       ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  entry_t            fifo_q [FIFO_DEPTH];
  entry_t            fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic permit_c, req_c, accept_c, push_c, pop_c, valid_c;
  logic unused_rpc_lsb;

  // Halfword fetch: the redirect target LSB carries no information
  assign unused_rpc_lsb = bus.redirect_pc[0];

  // Issue permission reserves a slot for the in-flight response so the buffer cannot overflow
  always_comb begin
    permit_c = 1'b0;
    case (state_q)
      S_REQ:   permit_c = count_q < CNT_W'(FIFO_DEPTH);
      S_WAIT:  permit_c = bus.imem_rvalid && (count_q < CNT_W'(FIFO_DEPTH - 1));
      default: permit_c = 1'b0;
    endcase
  end

  assign req_c    = permit_c & ~bus.redirect & reset;
  assign accept_c = req_c & bus.imem_ready;
  assign valid_c  = (count_q != '0) & ~bus.redirect;
  assign pop_c    = valid_c & bus.instr_ready;
  assign push_c   = (state_q == S_WAIT) & bus.imem_rvalid & ~bus.redirect;

  assign bus.imem_req    = req_c;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = valid_c;
  assign bus.instruction = fifo_q[rd_ptr_q].instr;
  assign bus.instr_pc    = fifo_q[rd_ptr_q].pc;

  // Next state for the request FSM, fetch PC and instruction buffer
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    fifo_d     = fifo_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    case (state_q)
      S_REQ:  if (accept_c) state_d = S_WAIT;
      S_WAIT: begin
        if (bus.imem_rvalid)       state_d = accept_c ? S_WAIT : S_REQ;
        else if (bus.redirect)     state_d = S_DROP;
      end
      S_DROP: if (bus.imem_rvalid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase

    if (accept_c) req_pc_d = fetch_pc_q;

    if (bus.redirect) begin
      fetch_pc_d = {bus.redirect_pc[ADDR_W-1:1], 1'b0};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (accept_c) fetch_pc_d = fetch_pc_q + ADDR_W'(2);
      if (push_c) begin
        fifo_d[wr_ptr_q] = '{instr: bus.imem_rdata, pc: req_pc_q};
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset also clears the buffer so the decoder sees defined values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_q[i] <= '{instr: '0, pc: RESET_PC};
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fifo_q     <= fifo_d;
    end
  end

  // The issue rule must make a push into a full buffer impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push_c && (count_q == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural instruction memory, in-order scoreboard,
// a startup vector table and hand-written redirect / stall / wrap / reset sequences.
module tb_fetch_unit;

  logic clk;
  logic reset;

  fetch_unit_if #(.ADDR_W(16)) bus ();

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  typedef struct {
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] pc;
    logic [15:0] instr;
  } vec_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_deliv = 0;
  int          n_fetch10 = 0;
  logic [15:0] exp_fetch;

  // memory model state
  int          mem_lat;
  logic        pend;
  logic [15:0] paddr;
  int          cd;
  logic        acc_last, done_last;
  logic [15:0] acc_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sample handshakes at mid-cycle: scoreboard pops/pushes and memory acceptance
  task automatic observe();
    exp_t e;
    acc_last  = 1'b0;
    done_last = 1'b0;
    if (!reset) return;
    if (bus.redirect) begin
      sb.delete();
      exp_fetch = {bus.redirect_pc[15:1], 1'b0};
    end else if (bus.instr_valid && bus.instr_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_pop", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("sb_pc", 32'(bus.instr_pc), 32'(e.pc));
        check("sb_instr", 32'(bus.instruction), 32'(e.instr));
        n_deliv++;
      end
    end
    if (bus.imem_req && bus.imem_ready) begin
      check("fetch_addr", 32'(bus.imem_addr), 32'(exp_fetch));
      sb.push_back('{pc: exp_fetch, instr: exp_fetch ^ 16'hA5A5});
      if (exp_fetch == 16'h0010) n_fetch10++;
      exp_fetch = exp_fetch + 16'd2;
      acc_last  = 1'b1;
      acc_addr  = bus.imem_addr;
    end
    done_last = bus.imem_rvalid;
  endtask

  // Advance the memory model after a clock edge
  task automatic drive_mem();
    if (done_last) pend = 1'b0;
    else if (pend && cd > 0) cd--;
    if (acc_last) begin
      pend  = 1'b1;
      paddr = acc_addr;
      cd    = mem_lat - 1;
    end
    bus.imem_rvalid = pend && (cd == 0);
    bus.imem_rdata  = bus.imem_rvalid ? (paddr ^ 16'hA5A5) : 16'($urandom);
  endtask

  task automatic sync();
    @(negedge clk);
  endtask

  task automatic tick();
    #1;
    observe();
    @(posedge clk);
    #1;
    drive_mem();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      sync();
      tick();
    end
  endtask

  task automatic clear_model();
    sb.delete();
    exp_fetch       = 16'h0000;
    pend            = 1'b0;
    cd              = 0;
    acc_last        = 1'b0;
    done_last       = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 16'h0000;
    n_fetch10       = 0;
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.instr_ready = 1'b1;
    bus.imem_ready  = 1'b1;
    mem_lat         = 1;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_imem_addr", 32'(bus.imem_addr), 32'h0000);
    check("rst_instruction", 32'(bus.instruction), 32'h0000);
    check("rst_instr_pc", 32'(bus.instr_pc), 32'h0000);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int   d0;
    logic found;

    tbl[0] = '{req: 1'b1, addr: 16'h0000, valid: 1'b0, pc: 16'h0000, instr: 16'h0000};
    tbl[1] = '{req: 1'b1, addr: 16'h0002, valid: 1'b0, pc: 16'h0000, instr: 16'h0000};
    tbl[2] = '{req: 1'b1, addr: 16'h0004, valid: 1'b1, pc: 16'h0000, instr: 16'hA5A5};
    tbl[3] = '{req: 1'b1, addr: 16'h0006, valid: 1'b1, pc: 16'h0002, instr: 16'hA5A7};
    tbl[4] = '{req: 1'b1, addr: 16'h0008, valid: 1'b1, pc: 16'h0004, instr: 16'hA5A1};
    tbl[5] = '{req: 1'b1, addr: 16'h000A, valid: 1'b1, pc: 16'h0006, instr: 16'hA5A3};

    // Startup latency and back-to-back delivery
    do_reset();
    for (int i = 0; i < 6; i++) begin
      sync();
      check($sformatf("start%0d_req", i), 32'(bus.imem_req), 32'(tbl[i].req));
      check($sformatf("start%0d_addr", i), 32'(bus.imem_addr), 32'(tbl[i].addr));
      check($sformatf("start%0d_valid", i), 32'(bus.instr_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) begin
        check($sformatf("start%0d_pc", i), 32'(bus.instr_pc), 32'(tbl[i].pc));
        check($sformatf("start%0d_instr", i), 32'(bus.instruction), 32'(tbl[i].instr));
      end
      tick();
    end
    d0 = n_deliv;
    run(20);
    check("throughput", 32'(n_deliv - d0), 32'd20);

    // Decoder stall fills the buffer, then drains without gaps
    sync();
    bus.instr_ready = 1'b0;
    tick();
    run(10);
    sync();
    check("stall_buffered", 32'(sb.size()), 32'd4);
    check("stall_req", 32'(bus.imem_req), 32'd0);
    check("stall_valid", 32'(bus.instr_valid), 32'd1);
    bus.instr_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      sync();
      check($sformatf("drain%0d_valid", i), 32'(bus.instr_valid), 32'd1);
      tick();
    end

    // Memory back-pressure holds the request address
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      sync();
      if (bus.imem_req && bus.imem_addr == 16'h0010) found = 1'b1;
      if (found) break;
      tick();
    end
    check("bp_found", 32'(found), 32'd1);
    bus.imem_ready = 1'b0;
    #1;
    check("bp_req0", 32'(bus.imem_req), 32'd1);
    check("bp_addr0", 32'(bus.imem_addr), 32'h0010);
    tick();
    for (int i = 1; i < 3; i++) begin
      sync();
      check($sformatf("bp_req%0d", i), 32'(bus.imem_req), 32'd1);
      check($sformatf("bp_addr%0d", i), 32'(bus.imem_addr), 32'h0010);
      tick();
    end
    sync();
    bus.imem_ready = 1'b1;
    #1;
    check("bp_req_rel", 32'(bus.imem_req), 32'd1);
    check("bp_addr_rel", 32'(bus.imem_addr), 32'h0010);
    tick();
    run(6);
    check("bp_fetch_once", 32'(n_fetch10), 32'd1);

    // Redirect while a late response is outstanding: drop it, refetch at the target
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      sync();
      if (bus.imem_req && bus.imem_addr == 16'h0008) found = 1'b1;
      if (found) mem_lat = 3;
      tick();
      if (found) break;
    end
    check("drop_found", 32'(found), 32'd1);
    sync();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0101;
    #1;
    check("drop_a_req", 32'(bus.imem_req), 32'd0);
    check("drop_a_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    sync();
    bus.redirect = 1'b0;
    #1;
    check("drop_b_req", 32'(bus.imem_req), 32'd0);
    check("drop_b_rvalid", 32'(bus.imem_rvalid), 32'd0);
    tick();
    sync();
    check("drop_c_rvalid", 32'(bus.imem_rvalid), 32'd1);
    check("drop_c_req", 32'(bus.imem_req), 32'd0);
    check("drop_c_valid", 32'(bus.instr_valid), 32'd0);
    mem_lat = 1;
    tick();
    sync();
    check("drop_d_req", 32'(bus.imem_req), 32'd1);
    check("drop_d_addr", 32'(bus.imem_addr), 32'h0100);
    tick();
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sync();
      if (bus.instr_valid) begin
        found = 1'b1;
        check("drop_first_pc", 32'(bus.instr_pc), 32'h0100);
        check("drop_first_instr", 32'(bus.instruction), 32'(16'h0100 ^ 16'hA5A5));
      end
      tick();
      if (found) break;
    end
    check("drop_deliver", 32'(found), 32'd1);

    // Redirect coincident with a response and a pop, three entries buffered
    do_reset();
    bus.instr_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 32; i++) begin
      sync();
      if (sb.size() == 4 && bus.imem_rvalid) begin
        found = 1'b1;
        bus.instr_ready = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0040;
        #1;
        check("flush_valid", 32'(bus.instr_valid), 32'd0);
        check("flush_req", 32'(bus.imem_req), 32'd0);
      end
      tick();
      if (found) break;
    end
    check("flush_found", 32'(found), 32'd1);
    sync();
    bus.redirect = 1'b0;
    #1;
    check("flush_empty", 32'(bus.instr_valid), 32'd0);
    check("flush_req_next", 32'(bus.imem_req), 32'd1);
    check("flush_addr_next", 32'(bus.imem_addr), 32'h0040);
    tick();
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sync();
      if (bus.instr_valid) begin
        found = 1'b1;
        check("flush_first_pc", 32'(bus.instr_pc), 32'h0040);
      end
      tick();
      if (found) break;
    end
    check("flush_deliver", 32'(found), 32'd1);

    // PC wrap at the top of the address space, then asynchronous reset mid-WAIT
    do_reset();
    run(4);
    sync();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFF;
    bus.instr_ready = 1'b0;
    tick();
    sync();
    bus.redirect = 1'b0;
    #1;
    check("wrap_req", 32'(bus.imem_req), 32'd1);
    check("wrap_addr_top", 32'(bus.imem_addr), 32'hFFFE);
    mem_lat = 3;
    tick();
    sync();
    check("wrap_addr_zero", 32'(bus.imem_addr), 32'h0000);
    tick();
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sync();
      if (bus.instr_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("wrap_deliver", 32'(found), 32'd1);
    check("wrap_head_pc", 32'(bus.instr_pc), 32'hFFFE);
    check("wrap_head_instr", 32'(bus.instruction), 32'(16'hFFFE ^ 16'hA5A5));
    check("wrap_waiting", 32'(bus.imem_rvalid), 32'd0);
    #1;
    reset = 1'b0;
    #1;
    check("arst_req", 32'(bus.imem_req), 32'd0);
    check("arst_valid", 32'(bus.instr_valid), 32'd0);
    check("arst_addr", 32'(bus.imem_addr), 32'h0000);
    check("arst_instruction", 32'(bus.instruction), 32'h0000);
    check("arst_instr_pc", 32'(bus.instr_pc), 32'h0000);
    bus.instr_ready = 1'b1;
    mem_lat         = 1;
    clear_model();
    @(posedge clk);
    #1;
    reset = 1'b1;
    sync();
    check("restart_req", 32'(bus.imem_req), 32'd1);
    check("restart_addr", 32'(bus.imem_addr), 32'h0000);
    tick();
    run(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the instruction decoder. It owns the fetch program counter and issues halfword requests to instruction memory with a valid/ready handshake. Returned 16-bit instructions are buffered in a small FIFO and presented to the decoder together with their PC. A branch redirect flushes the stage and restarts fetch at a new address.

## Interface
- ADDR_W, 16, width of byte addresses and PCs.
- RESET_PC, 16'h0000, fetch address after reset; must be even.
- FIFO_DEPTH, 4, instruction buffer entries; power of 2, ≥2.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch byte address; always equals fetch_pc.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  16  returned instruction.
- instr_valid  out  1  buffer head valid.
- instruction  out  16  buffer head instruction, driven to the decoder.
- instr_pc  out  ADDR_W  address of the buffer head.
- instr_ready  in  1  decoder consumes the head this cycle.
- redirect  in  1  branch taken; flush and refetch.
- redirect_pc  in  ADDR_W  new fetch address; bit 0 is ignored and forced to 0.

## Operation
- Registers:
  - fetch_pc (ADDR_W)
  - state (REQ, WAIT, DROP)
  - req_pc: PC of the outstanding request
  - FIFO storage {instr, pc} × FIFO_DEPTH, with rd_ptr, wr_ptr, and a count of width log2(FIFO_DEPTH)+1.
- At most one request is outstanding. Responses return in order and are never dropped by memory.
- Issue permission (does not depend on instr_ready):
  - In REQ: count < FIFO_DEPTH.
  - In WAIT with imem_rvalid=1: count < FIFO_DEPTH-1.
  - Otherwise: not permitted.
- imem_req = permission & ~redirect & reset. It is forced to 0 while reset is low.
- Handshake: a request is accepted when imem_req & imem_ready. On acceptance:
  - req_pc <= fetch_pc
  - fetch_pc <= fetch_pc + 2, wrapping modulo 2^ADDR_W
  - state <= WAIT
- imem_req may stay asserted across cycles while imem_ready=0. imem_addr must remain stable until acceptance.
- State transitions:
  - REQ: on acceptance, go to WAIT.
  - WAIT, imem_rvalid=1: push {imem_rdata, req_pc}. Go to WAIT if a new request is accepted in the same cycle, else go to REQ.
  - WAIT, redirect=1 & imem_rvalid=0: go to DROP.
  - WAIT, redirect=1 & imem_rvalid=1: discard the response (no push) and go to REQ.
  - DROP, imem_rvalid=1: discard the response and go to REQ. No request is issued while in DROP.
- Redirect (highest priority):
  - FIFO is flushed (count, rd_ptr and wr_ptr <= 0).
  - fetch_pc <= {redirect_pc[ADDR_W-1:1], 0}.
  - Any pop or push in the same cycle is void.
  - A redirect while in DROP updates fetch_pc and stays in DROP.
- Output side:
  - instr_valid = (count != 0) & ~redirect.
  - instruction and instr_pc are taken from FIFO[rd_ptr].
  - Pop occurs on instr_valid & instr_ready.
  - Simultaneous push and pop leaves count unchanged.
- Overflow is impossible by the issue rule. A push into a full FIFO is an assertion failure in verification.

## Timing
- Reset values:
  - imem_req=0, instr_valid=0
  - imem_addr=RESET_PC
  - instruction=16'h0000, instr_pc=RESET_PC (storage is cleared)
  - state=REQ, count=0
- Startup: imem_req=1 in the first cycle after reset is released.
- Latency with a zero-wait memory (imem_ready=1, imem_rvalid the cycle after acceptance):
  - Request accepted at cycle N.
  - Push at the edge ending cycle N+1.
  - instr_valid=1 in cycle N+2.
- Steady-state throughput is 1 instruction per cycle with zero-wait memory and an always-ready decoder.
- Redirect asserted in cycle N: the new address appears on imem_addr with imem_req=1 in cycle N+1. This holds if no response is pending; otherwise it follows the cycle of the discarded response.
- Reset asserted mid-operation immediately forces all reset values, including abandoning any outstanding request. Memory must tolerate this.

## Test plan
- Reset, then zero-wait memory returning rdata = addr ^ 16'hA5A5, decoder always ready -> instructions from 0x0000, 0x0002, 0x0004, ... presented on consecutive cycles starting at cycle 2, with matching instr_pc.
- instr_ready=0 for 10 cycles -> exactly 4 entries buffered and imem_req drops to 0. Releasing ready delivers PCs in order with no gap or duplicate.
- imem_ready low for 3 cycles at addr 0x0010 -> imem_addr holds 0x0010 and imem_req stays 1, then 0x0010 is fetched exactly once.
- Redirect to 0x0101 while a response for 0x0008 is 2 cycles late -> state goes to DROP and the late response is discarded. The next request is 0x0100 and the next instr_pc is 0x0100.
- Redirect in the same cycle as imem_rvalid and a pop with 3 entries buffered -> count=0 the following cycle and the response is not pushed. Fetch resumes at redirect_pc.
- fetch_pc=16'hFFFE -> the next fetch address wraps to 16'h0000. Asserting reset mid-WAIT returns all outputs to their reset values asynchronously.
